// File: rtl/uart_tx_arbiter_pkg.sv
// Shared encodings for the UART TX arbiter: FSM states and requester IDs.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_GAP     = 3'd4
    } arb_state_t;

    localparam logic GNT_ALU = 1'b0;
    localparam logic GNT_RF  = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART TX handshake bundle shared by the arbiter and its environment.
interface uart_tx_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      alu_vld;
    logic [2*DATA_WIDTH-1:0]   alu_data;
    logic                      alu_ack;
    logic                      rf_vld;
    logic [DATA_WIDTH-1:0]     rf_data;
    logic                      rf_ack;
    logic                      tx_busy;
    logic [DATA_WIDTH-1:0]     tx_p_data;
    logic                      tx_vld;
    logic                      arb_busy;
    logic                      to_err;

    modport slave (
        input  alu_vld, alu_data, rf_vld, rf_data, tx_busy,
        output alu_ack, rf_ack, tx_p_data, tx_vld, arb_busy, to_err
    );

    modport master (
        output alu_vld, alu_data, rf_vld, rf_data, tx_busy,
        input  alu_ack, rf_ack, tx_p_data, tx_vld, arb_busy, to_err
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last winner loses the next tie.
module uart_tx_arbiter_rr_arb2
    import uart_tx_arbiter_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_alu,
    input  logic i_req_rf,
    input  logic i_take,
    output logic o_gnt_vld,
    output logic o_gnt_id
);
    logic r_last_grant;
    logic w_gnt_id;

    always_comb begin
        w_gnt_id = GNT_ALU;
        if (i_req_alu && i_req_rf)
            w_gnt_id = (r_last_grant == GNT_ALU) ? GNT_RF : GNT_ALU;
        else if (i_req_rf)
            w_gnt_id = GNT_RF;
    end

    // Reset to RF so the first tie goes to the ALU.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_last_grant <= GNT_RF;
        else if (i_take && o_gnt_vld)
            r_last_grant <= w_gnt_id;
    end

    assign o_gnt_vld = i_req_alu | i_req_rf;
    assign o_gnt_id  = w_gnt_id;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Serialises ALU (2-byte) and register-file (1-byte) packets onto one UART transmitter,
// pacing each byte off TX BUSY with an optional inter-byte gap and a BUSY-rise timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int GAP_CYCLES   = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    uart_tx_arbiter_if.slave       io_bus
);
    localparam int TO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    arb_state_t                r_state, w_state_next;
    logic [2*DATA_WIDTH-1:0]   r_shift, w_shift_next;
    logic [1:0]                r_bytes_left, w_bytes_left_next;
    logic [TO_W-1:0]           r_to_cnt, w_to_cnt_next;
    logic [GAP_W-1:0]          r_gap_cnt, w_gap_cnt_next;
    logic                      r_alu_ack, w_alu_ack_next;
    logic                      r_rf_ack, w_rf_ack_next;
    logic                      r_tx_vld, w_tx_vld_next;
    logic [DATA_WIDTH-1:0]     r_tx_data, w_tx_data_next;
    logic                      r_arb_busy, w_arb_busy_next;
    logic                      r_to_err, w_to_err_next;
    logic                      w_take, w_byte_done, w_gnt_vld, w_gnt_id;

    uart_tx_arbiter_rr_arb2 u_rr_arb2 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req_alu (io_bus.alu_vld),
        .i_req_rf  (io_bus.rf_vld),
        .i_take    (w_take),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_id  (w_gnt_id)
    );

    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_bytes_left_next = r_bytes_left;
        w_to_cnt_next     = r_to_cnt;
        w_gap_cnt_next    = r_gap_cnt;
        w_alu_ack_next    = 1'b0;
        w_rf_ack_next     = 1'b0;
        w_tx_vld_next     = 1'b0;
        w_tx_data_next    = r_tx_data;
        w_arb_busy_next   = r_arb_busy;
        w_to_err_next     = r_to_err;
        w_take            = 1'b0;
        w_byte_done       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld) begin
                    w_take          = 1'b1;
                    w_arb_busy_next = 1'b1;
                    w_state_next    = ST_SEND;
                    if (w_gnt_id == GNT_ALU) begin
                        w_shift_next      = io_bus.alu_data;
                        w_bytes_left_next = 2'd2;
                        w_alu_ack_next    = 1'b1;
                    end else begin
                        w_shift_next      = {{DATA_WIDTH{1'b0}}, io_bus.rf_data};
                        w_bytes_left_next = 2'd1;
                        w_rf_ack_next     = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (!io_bus.tx_busy) begin
                    w_tx_vld_next  = 1'b1;
                    w_tx_data_next = r_shift[DATA_WIDTH-1:0];
                    w_to_cnt_next  = '0;
                    w_state_next   = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (io_bus.tx_busy) begin
                    w_state_next = ST_WAIT_LO;
                end else if (r_to_cnt == TO_LAST) begin
                    // Transmitter never acknowledged: drop the byte and flag it.
                    w_to_err_next = 1'b1;
                    w_byte_done   = 1'b1;
                end else begin
                    w_to_cnt_next = r_to_cnt + 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!io_bus.tx_busy)
                    w_byte_done = 1'b1;
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST)
                    w_state_next = ST_SEND;
                else
                    w_gap_cnt_next = r_gap_cnt + 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_byte_done) begin
            w_shift_next      = r_shift >> DATA_WIDTH;
            w_bytes_left_next = r_bytes_left - 2'd1;
            if (r_bytes_left == 2'd1) begin
                w_arb_busy_next = 1'b0;
                w_state_next    = ST_IDLE;
            end else if (GAP_CYCLES == 0) begin
                w_state_next = ST_SEND;
            end else begin
                w_gap_cnt_next = '0;
                w_state_next   = ST_GAP;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bytes_left <= '0;
            r_to_cnt     <= '0;
            r_gap_cnt    <= '0;
            r_alu_ack    <= 1'b0;
            r_rf_ack     <= 1'b0;
            r_tx_vld     <= 1'b0;
            r_tx_data    <= '0;
            r_arb_busy   <= 1'b0;
            r_to_err     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bytes_left <= w_bytes_left_next;
            r_to_cnt     <= w_to_cnt_next;
            r_gap_cnt    <= w_gap_cnt_next;
            r_alu_ack    <= w_alu_ack_next;
            r_rf_ack     <= w_rf_ack_next;
            r_tx_vld     <= w_tx_vld_next;
            r_tx_data    <= w_tx_data_next;
            r_arb_busy   <= w_arb_busy_next;
            r_to_err     <= w_to_err_next;
        end
    end

    assign io_bus.alu_ack   = r_alu_ack;
    assign io_bus.rf_ack    = r_rf_ack;
    assign io_bus.tx_vld    = r_tx_vld;
    assign io_bus.tx_p_data = r_tx_data;
    assign io_bus.arb_busy  = r_arb_busy;
    assign io_bus.to_err    = r_to_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: UART TX model (BUSY one cycle after DATA_VALID, held 10 cycles),
// directed scenarios plus randomized packets checked against a packet-order model.
module tb_uart_tx_arbiter;
    localparam int DW       = 8;
    localparam int GAP      = 2;
    localparam int TMO      = 16;
    localparam int BUSY_LEN = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .DATA_WIDTH   (DW),
        .GAP_CYCLES   (GAP),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // UART TX model
    int   busy_cnt = 0;
    logic model_en;
    logic ext_busy;
    always @(posedge clk) begin
        if (model_en && bus.tx_vld)
            busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt != 0) || ext_busy;

    // Monitor: sampled on the falling edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] sent_q[$];
    int sent_cyc[$];
    int fall_q[$];
    int arb_fall_q[$];
    int vld_while_busy = 0;
    int alu_ack_cnt = 0, rf_ack_cnt = 0;
    int last_alu_ack_cyc = -1, last_rf_ack_cyc = -1, to_err_rise_cyc = -1;
    logic prev_busy = 1'b0, prev_arb = 1'b0, prev_err = 1'b0;

    always @(negedge clk) begin
        if (bus.tx_vld) begin
            sent_q.push_back(bus.tx_p_data);
            sent_cyc.push_back(cyc);
            if (bus.tx_busy) vld_while_busy++;
        end
        if (bus.alu_ack) begin alu_ack_cnt++; last_alu_ack_cyc = cyc; end
        if (bus.rf_ack)  begin rf_ack_cnt++;  last_rf_ack_cyc  = cyc; end
        if (prev_busy && !bus.tx_busy) fall_q.push_back(cyc);
        if (prev_arb && !bus.arb_busy) arb_fall_q.push_back(cyc);
        if (!prev_err && bus.to_err) to_err_rise_cyc = cyc;
        prev_busy = bus.tx_busy;
        prev_arb  = bus.arb_busy;
        prev_err  = bus.to_err;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        sent_q.delete();
        sent_cyc.delete();
        fall_q.delete();
        arb_fall_q.delete();
        to_err_rise_cyc = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic req_alu(input logic [2*DW-1:0] d, output bit ok);
        bus.alu_data = d;
        bus.alu_vld  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (bus.alu_ack) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.alu_vld = 1'b0;
    endtask

    task automatic req_rf(input logic [DW-1:0] d, output bit ok);
        bus.rf_data = d;
        bus.rf_vld  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (bus.rf_ack) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.rf_vld = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (!bus.arb_busy && !bus.tx_busy && !bus.alu_vld && !bus.rf_vld) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.alu_ack, bus.rf_ack, bus.tx_vld, bus.tx_p_data, bus.arb_busy, bus.to_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %0h want 0",
                     {bus.alu_ack, bus.rf_ack, bus.tx_vld, bus.tx_p_data, bus.arb_busy, bus.to_err});
        end
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.arb_busy, bus.tx_vld} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_idle: got %b want 00", {bus.arb_busy, bus.tx_vld});
        end
    endtask

    task automatic test_rf_single();
        bit ok, ok2;
        int ack0, t_req;
        clear_logs();
        ack0  = rf_ack_cnt;
        t_req = cyc;
        req_rf(8'hA5, ok);
        wait_idle(ok2);
        vectors++;
        if (!(ok && ok2)) begin
            miscompares++;
            $display("FAIL rf_handshake: got ack=%0d idle=%0d want 1 1", ok, ok2);
        end
        vectors++;
        if (rf_ack_cnt - ack0 !== 1) begin
            miscompares++;
            $display("FAIL rf_ack_width: got %0d cycles want 1", rf_ack_cnt - ack0);
        end
        vectors++;
        if (last_rf_ack_cyc - t_req !== 1) begin
            miscompares++;
            $display("FAIL rf_ack_latency: got %0d want 1", last_rf_ack_cyc - t_req);
        end
        vectors++;
        if (sent_q.size() !== 1) begin
            miscompares++;
            $display("FAIL rf_byte_count: got %0d want 1", sent_q.size());
        end else begin
            vectors++;
            if (sent_q[0] !== 8'hA5) begin
                miscompares++;
                $display("FAIL rf_byte: got %0h want a5", sent_q[0]);
            end
            vectors++;
            if (sent_cyc[0] - last_rf_ack_cyc !== 1) begin
                miscompares++;
                $display("FAIL rf_vld_latency: got %0d want 1", sent_cyc[0] - last_rf_ack_cyc);
            end
        end
        vectors++;
        if (fall_q.size() < 1 || arb_fall_q.size() < 1) begin
            miscompares++;
            $display("FAIL rf_arb_drop: got fall events %0d/%0d want both", fall_q.size(), arb_fall_q.size());
        end else if (arb_fall_q[0] - fall_q[0] !== 1) begin
            miscompares++;
            $display("FAIL rf_arb_drop: got %0d cycles after BUSY fall want 1", arb_fall_q[0] - fall_q[0]);
        end
    endtask

    task automatic test_alu_gap();
        bit ok, ok2;
        clear_logs();
        req_alu(16'h1234, ok);
        wait_idle(ok2);
        vectors++;
        if (!(ok && ok2)) begin
            miscompares++;
            $display("FAIL alu_handshake: got ack=%0d idle=%0d want 1 1", ok, ok2);
        end
        vectors++;
        if (sent_q.size() !== 2 || fall_q.size() < 1) begin
            miscompares++;
            $display("FAIL alu_byte_count: got %0d want 2", sent_q.size());
        end else begin
            vectors++;
            if ({sent_q[0], sent_q[1]} !== 16'h3412) begin
                miscompares++;
                $display("FAIL alu_bytes: got %0h %0h want 34 12", sent_q[0], sent_q[1]);
            end
            // BUSY low is seen one cycle late, then GAP idle cycles, then one SEND cycle.
            vectors++;
            if (sent_cyc[1] - fall_q[0] !== GAP + 2) begin
                miscompares++;
                $display("FAIL alu_gap: got %0d idle cycles want %0d", sent_cyc[1] - fall_q[0] - 2, GAP);
            end
        end
    endtask

    task automatic test_tie();
        bit ok_a1, ok_a2, ok_r, ok2;
        logic [DW-1:0] exp_b[5];
        do_reset();
        clear_logs();
        exp_b = '{8'hEF, 8'hBE, 8'h5A, 8'hDE, 8'hC0};
        fork
            begin
                req_alu(16'hBEEF, ok_a1);
                req_alu(16'hC0DE, ok_a2);
            end
            req_rf(8'h5A, ok_r);
        join
        wait_idle(ok2);
        vectors++;
        if (!(ok_a1 && ok_a2 && ok_r && ok2)) begin
            miscompares++;
            $display("FAIL tie_handshake: got %0d%0d%0d%0d want 1111", ok_a1, ok_a2, ok_r, ok2);
        end
        vectors++;
        if (sent_q.size() !== 5) begin
            miscompares++;
            $display("FAIL tie_byte_count: got %0d want 5", sent_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (sent_q[i] !== exp_b[i]) begin
                    miscompares++;
                    $display("FAIL tie_byte%0d: got %0h want %0h", i, sent_q[i], exp_b[i]);
                end
            end
        end
        vectors++;
        if (arb_fall_q.size() < 1 || last_rf_ack_cyc - arb_fall_q[0] !== 1) begin
            miscompares++;
            $display("FAIL tie_rf_capture: got rf ack at %0d want one cycle after arb drop", last_rf_ack_cyc);
        end
    endtask

    task automatic test_timeout();
        bit ok, ok2;
        clear_logs();
        model_en = 1'b0;
        req_alu(16'hA55A, ok);
        wait_idle(ok2);
        model_en = 1'b1;
        vectors++;
        if (!(ok && ok2)) begin
            miscompares++;
            $display("FAIL to_handshake: got ack=%0d idle=%0d want 1 1", ok, ok2);
        end
        vectors++;
        if (sent_q.size() !== 2) begin
            miscompares++;
            $display("FAIL to_byte_count: got %0d want 2", sent_q.size());
        end else begin
            vectors++;
            if ({sent_q[0], sent_q[1]} !== 16'h5AA5) begin
                miscompares++;
                $display("FAIL to_bytes: got %0h %0h want 5a a5", sent_q[0], sent_q[1]);
            end
            vectors++;
            if (to_err_rise_cyc - sent_cyc[0] !== TMO) begin
                miscompares++;
                $display("FAIL to_err_delay: got %0d want %0d", to_err_rise_cyc - sent_cyc[0], TMO);
            end
        end
        vectors++;
        if (bus.to_err !== 1'b1) begin
            miscompares++;
            $display("FAIL to_err_sticky: got %b want 1", bus.to_err);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs();
        req_alu(16'h7788, ok);
        for (int i = 0; i < 20; i++) begin
            if (bus.tx_busy) break;
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.alu_ack, bus.rf_ack, bus.tx_vld, bus.tx_p_data, bus.arb_busy, bus.to_err} !== '0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %0h want 0",
                     {bus.alu_ack, bus.rf_ack, bus.tx_vld, bus.tx_p_data, bus.arb_busy, bus.to_err});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        vectors++;
        if (sent_q.size() !== 1 || !ok) begin
            miscompares++;
            $display("FAIL midrst_no_resume: got %0d bytes want 1", sent_q.size());
        end else begin
            vectors++;
            if (sent_q[0] !== 8'h88) begin
                miscompares++;
                $display("FAIL midrst_first_byte: got %0h want 88", sent_q[0]);
            end
        end
        vectors++;
        if (bus.arb_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_arb_busy: got %b want 0", bus.arb_busy);
        end
    endtask

    task automatic test_busy_hold();
        bit ok, ok2;
        int t_drop;
        clear_logs();
        ext_busy = 1'b1;
        req_rf(8'h3C, ok);
        repeat (15) @(posedge clk);
        #1;
        vectors++;
        if (sent_q.size() !== 0) begin
            miscompares++;
            $display("FAIL hold_withheld: got %0d strobes want 0", sent_q.size());
        end
        t_drop   = cyc;
        ext_busy = 1'b0;
        wait_idle(ok2);
        vectors++;
        if (!(ok && ok2) || sent_q.size() !== 1) begin
            miscompares++;
            $display("FAIL hold_byte_count: got %0d want 1", sent_q.size());
        end else begin
            vectors++;
            if (sent_q[0] !== 8'h3C) begin
                miscompares++;
                $display("FAIL hold_byte: got %0h want 3c", sent_q[0]);
            end
            vectors++;
            if (sent_cyc[0] - t_drop !== 1) begin
                miscompares++;
                $display("FAIL hold_release: got %0d want 1", sent_cyc[0] - t_drop);
            end
        end
    endtask

    task automatic test_random();
        bit ok_a, ok_r, ok2;
        bit last_rf;
        int mode;
        logic [2*DW-1:0] a;
        logic [DW-1:0] r;
        logic [DW-1:0] exp_q[$];
        do_reset();
        last_rf = 1'b1;
        for (int it = 0; it < 12; it++) begin
            mode = $urandom_range(0, 2);
            a = 16'($urandom);
            r = 8'($urandom);
            clear_logs();
            exp_q.delete();
            ok_a = 1'b1;
            ok_r = 1'b1;
            if (mode == 0) begin
                exp_q.push_back(a[7:0]); exp_q.push_back(a[15:8]);
                last_rf = 1'b0;
                req_alu(a, ok_a);
            end else if (mode == 1) begin
                exp_q.push_back(r);
                last_rf = 1'b1;
                req_rf(r, ok_r);
            end else begin
                if (last_rf) begin
                    exp_q.push_back(a[7:0]); exp_q.push_back(a[15:8]); exp_q.push_back(r);
                    last_rf = 1'b1;
                end else begin
                    exp_q.push_back(r); exp_q.push_back(a[7:0]); exp_q.push_back(a[15:8]);
                    last_rf = 1'b0;
                end
                fork
                    req_alu(a, ok_a);
                    req_rf(r, ok_r);
                join
            end
            wait_idle(ok2);
            vectors++;
            if (!(ok_a && ok_r && ok2) || sent_q.size() !== exp_q.size()) begin
                miscompares++;
                $display("FAIL rand%0d_count: got %0d bytes want %0d (mode %0d)", it, sent_q.size(), exp_q.size(), mode);
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    vectors++;
                    if (sent_q[i] !== exp_q[i]) begin
                        miscompares++;
                        $display("FAIL rand%0d_byte%0d: got %0h want %0h (mode %0d)", it, i, sent_q[i], exp_q[i], mode);
                    end
                end
            end
        end
        vectors++;
        if (bus.to_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_to_err: got %b want 0", bus.to_err);
        end
    endtask

    initial begin
        model_en     = 1'b1;
        ext_busy     = 1'b0;
        bus.alu_vld  = 1'b0;
        bus.alu_data = '0;
        bus.rf_vld   = 1'b0;
        bus.rf_data  = '0;

        test_reset();
        test_rf_single();
        test_alu_gap();
        test_tie();
        test_timeout();
        test_reset_mid();
        test_busy_hold();
        test_random();

        vectors++;
        if (vld_while_busy !== 0) begin
            miscompares++;
            $display("FAIL vld_while_busy: got %0d strobes want 0", vld_while_busy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
